// File: rtl/banco_de_flags.sv
// Parametrised flag register for the PEPE-8 datapath: masked ALU flag capture,
// a save/restore stack for calls/interrupts and one selectable condition bit.
module banco_de_flags #(
  parameter int N_FLAGS     = 4,
  parameter int STACK_DEPTH = 4,
  parameter int SEL_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   sel_f,
  input  logic               escr_f,
  input  logic [N_FLAGS-1:0] mask_f,
  input  logic [N_FLAGS-2:0] r_flag,
  input  logic               bit_maior_peso,
  input  logic               push_f,
  input  logic               pop_f,
  output logic [N_FLAGS-1:0] flags,
  output logic               s_flag,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               stack_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [N_FLAGS-1:0] r_flags;
  logic [N_FLAGS-1:0] r_stack [STACK_DEPTH];
  logic [SP_W-1:0]    r_sp;
  logic               r_err;

  logic [N_FLAGS-1:0] w_wr_data;
  logic [N_FLAGS-1:0] w_written;
  logic               w_full;
  logic               w_empty;
  logic               w_do_push;
  logic               w_do_pop;
  logic               w_push_only;
  logic               w_pop_only;
  logic [IDX_W-1:0]   w_push_idx;
  logic [IDX_W-1:0]   w_pop_idx;
  logic [SP_W-1:0]    w_sp_dec;
  int unsigned        w_idx;
  logic               w_raw;

  assign w_wr_data   = {bit_maior_peso, r_flag};
  assign w_written   = (r_flags & ~mask_f) | (w_wr_data & mask_f);
  assign w_full      = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty     = (r_sp == '0);
  assign w_push_only = push_f & ~pop_f;
  assign w_pop_only  = pop_f & ~push_f;
  assign w_do_push   = w_push_only & ~w_full;
  assign w_do_pop    = w_pop_only & ~w_empty;
  assign w_sp_dec    = r_sp - 1'b1;
  assign w_push_idx  = r_sp[IDX_W-1:0];
  assign w_pop_idx   = w_sp_dec[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
      r_sp    <= '0;
      r_err   <= 1'b0;
    end else begin
      // A successful pop wins over the flag write; a failed pop does not.
      if (w_do_pop)
        r_flags <= r_stack[w_pop_idx];
      else if (escr_f)
        r_flags <= w_written;

      if (w_do_push)
        r_sp <= r_sp + 1'b1;
      else if (w_do_pop)
        r_sp <= w_sp_dec;

      if ((w_push_only && w_full) || (w_pop_only && w_empty))
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_do_push)
      r_stack[w_push_idx] <= r_flags;
  end

  // Indices beyond the stored flags read as "always" (or "never" when inverted).
  assign w_idx = 32'(sel_f[SEL_W-2:0]);

  always_comb begin
    w_raw = 1'b1;
    for (int i = 0; i < N_FLAGS; i++)
      if (w_idx == 32'(i))
        w_raw = r_flags[i];
  end

  assign flags       = r_flags;
  assign s_flag      = w_raw ^ sel_f[SEL_W-1];
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign stack_err   = r_err;

endmodule

// File: tb/tb_banco_de_flags.sv
// Directed self-checking bench for banco_de_flags with hand-computed expectations.
module tb_banco_de_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sel_f;
  logic       escr_f;
  logic [3:0] mask_f;
  logic [2:0] r_flag;
  logic       bit_maior_peso;
  logic       push_f;
  logic       pop_f;
  logic [3:0] flags;
  logic       s_flag;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  banco_de_flags #(.N_FLAGS(4), .STACK_DEPTH(4), .SEL_W(4)) dut (
    .clk(clk), .rst(rst), .sel_f(sel_f), .escr_f(escr_f), .mask_f(mask_f),
    .r_flag(r_flag), .bit_maior_peso(bit_maior_peso), .push_f(push_f),
    .pop_f(pop_f), .flags(flags), .s_flag(s_flag), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge, so outputs sampled there are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; escr_f = 1'b0; mask_f = 4'b0000; r_flag = 3'b000;
    bit_maior_peso = 1'b0; push_f = 1'b0; pop_f = 1'b0; sel_f = 4'b0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] v);
    escr_f = 1'b1; mask_f = 4'b1111; {bit_maior_peso, r_flag} = v;
    step();
    escr_f = 1'b0;
  endtask

  task automatic test_reset();
    set_flags(4'b1010);
    do_reset();
    n_compared++;
    if (flags !== 4'b0000) begin
      n_mismatched++; $display("[TB] FAIL reset_flags: got %b want %b", flags, 4'b0000);
    end
    n_compared++;
    if (stack_empty !== 1'b1 || stack_full !== 1'b0 || stack_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_status: got e=%b f=%b err=%b want e=1 f=0 err=0",
               stack_empty, stack_full, stack_err);
    end
  endtask

  task automatic test_flag_write();
    escr_f = 1'b1; mask_f = 4'b1111; r_flag = 3'b101; bit_maior_peso = 1'b1;
    step();
    escr_f = 1'b0;
    n_compared++;
    if (flags !== 4'b1101) begin
      n_mismatched++; $display("[TB] FAIL write_all: got %b want %b", flags, 4'b1101);
    end
    sel_f = 4'b0011; #1;
    n_compared++;
    if (s_flag !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL sel_n: got %b want 1", s_flag);
    end
    sel_f = 4'b1011; #1;
    n_compared++;
    if (s_flag !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL sel_n_inv: got %b want 0", s_flag);
    end
    sel_f = 4'b0001; #1;
    n_compared++;
    if (s_flag !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL sel_c: got %b want 0", s_flag);
    end
    escr_f = 1'b1; mask_f = 4'b0010; r_flag = 3'b010; bit_maior_peso = 1'b0;
    step();
    escr_f = 1'b0;
    n_compared++;
    if (flags !== 4'b1111) begin
      n_mismatched++; $display("[TB] FAIL write_masked: got %b want %b", flags, 4'b1111);
    end
    mask_f = 4'b1111; r_flag = 3'b000;
    step();
    n_compared++;
    if (flags !== 4'b1111) begin
      n_mismatched++; $display("[TB] FAIL write_disabled: got %b want %b", flags, 4'b1111);
    end
  endtask

  task automatic test_select();
    set_flags(4'b0000);
    sel_f = 4'b0100; #1;
    n_compared++;
    if (s_flag !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL sel_always: got %b want 1", s_flag);
    end
    sel_f = 4'b1111; #1;
    n_compared++;
    if (s_flag !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL sel_never: got %b want 0", s_flag);
    end
    sel_f = 4'b1000; #1;
    n_compared++;
    if (s_flag !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL sel_z_inv: got %b want 1", s_flag);
    end
    set_flags(4'b0100);
    sel_f = 4'b0010; #1;
    n_compared++;
    if (s_flag !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL sel_v: got %b want 1", s_flag);
    end
    sel_f = 4'b0000;
  endtask

  task automatic test_stack_fill();
    logic [3:0] vals [4];
    vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0100; vals[3] = 4'b1000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_flags(vals[i]);
      push_f = 1'b1;
      step();
      push_f = 1'b0;
    end
    n_compared++;
    if (stack_full !== 1'b1 || stack_empty !== 1'b0 || stack_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL stack_full: got f=%b e=%b err=%b want f=1 e=0 err=0",
               stack_full, stack_empty, stack_err);
    end
    set_flags(4'b1111);
    push_f = 1'b1;
    step();
    push_f = 1'b0;
    n_compared++;
    if (stack_err !== 1'b1 || stack_full !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL overflow: got err=%b f=%b want err=1 f=1", stack_err, stack_full);
    end
    for (int i = 3; i >= 0; i--) begin
      pop_f = 1'b1;
      step();
      pop_f = 1'b0;
      n_compared++;
      if (flags !== vals[i]) begin
        n_mismatched++; $display("[TB] FAIL pop_%0d: got %b want %b", i, flags, vals[i]);
      end
    end
    n_compared++;
    if (stack_empty !== 1'b1 || stack_full !== 1'b0 || stack_err !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL drained: got e=%b f=%b err=%b want e=1 f=0 err=1",
               stack_empty, stack_full, stack_err);
    end
  endtask

  task automatic test_pop_empty();
    do_reset();
    pop_f = 1'b1; escr_f = 1'b1; mask_f = 4'b1111; r_flag = 3'b110; bit_maior_peso = 1'b0;
    step();
    pop_f = 1'b0; escr_f = 1'b0;
    n_compared++;
    if (flags !== 4'b0110 || stack_err !== 1'b1 || stack_empty !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL underflow: got flags=%b err=%b e=%b want flags=0110 err=1 e=1",
               flags, stack_err, stack_empty);
    end
    push_f = 1'b1;
    step();
    push_f = 1'b0;
    step();
    n_compared++;
    if (stack_err !== 1'b1 || stack_empty !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL err_sticky: got err=%b e=%b want err=1 e=0", stack_err, stack_empty);
    end
    do_reset();
    n_compared++;
    if (stack_err !== 1'b0 || stack_empty !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL err_clear: got err=%b e=%b want err=0 e=1", stack_err, stack_empty);
    end
  endtask

  task automatic test_push_write();
    do_reset();
    set_flags(4'b0011);
    push_f = 1'b1; escr_f = 1'b1; mask_f = 4'b1111; {bit_maior_peso, r_flag} = 4'b1100;
    step();
    push_f = 1'b0; escr_f = 1'b0;
    n_compared++;
    if (flags !== 4'b1100 || stack_empty !== 1'b0 || stack_full !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL push_write: got flags=%b e=%b f=%b want flags=1100 e=0 f=0",
               flags, stack_empty, stack_full);
    end
    pop_f = 1'b1;
    step();
    pop_f = 1'b0;
    n_compared++;
    if (flags !== 4'b0011 || stack_empty !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL push_write_pop: got flags=%b e=%b want flags=0011 e=1",
               flags, stack_empty);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_flags(4'b0101);
    push_f = 1'b1;
    step();
    push_f = 1'b1; pop_f = 1'b1; escr_f = 1'b1; mask_f = 4'b1111;
    {bit_maior_peso, r_flag} = 4'b1010;
    step();
    push_f = 1'b0;
    n_compared++;
    if (flags !== 4'b1010 || stack_empty !== 1'b0 || stack_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL push_pop_both: got flags=%b e=%b err=%b want flags=1010 e=0 err=0",
               flags, stack_empty, stack_err);
    end
    {bit_maior_peso, r_flag} = 4'b1111;
    step();
    pop_f = 1'b0; escr_f = 1'b0;
    n_compared++;
    if (flags !== 4'b0101 || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL pop_priority: got flags=%b e=%b err=%b want flags=0101 e=1 err=0",
               flags, stack_empty, stack_err);
    end
    push_f = 1'b1; rst = 1'b1;
    step();
    push_f = 1'b0; rst = 1'b0;
    n_compared++;
    if (flags !== 4'b0000 || stack_empty !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_over_push: got flags=%b e=%b want flags=0000 e=1",
               flags, stack_empty);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    test_reset();
    test_flag_write();
    test_select();
    test_stack_fill();
    test_pop_empty();
    test_push_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/banco_de_flags.md
# banco_de_flags

Parametrised flag register for the PEPE-8 datapath, successor to the fixed 3+1-bit flag register. Captures ALU status flags plus the result MSB under a per-flag write mask. Provides a save/restore stack for calls and interrupts, and drives one selectable, optionally inverted condition bit to the jump logic. Sits between the ALU outputs and the control unit's conditional-branch input.

## Interface
- N_FLAGS, 4, number of stored flags; bits 0..N_FLAGS-2 come from the ALU, bit N_FLAGS-1 is the sign (MSB). Default order is Z, C, V, N.
- STACK_DEPTH, 4, number of save/restore entries (≥1).
- SEL_W, 4, width of the condition selector; must satisfy 2^(SEL_W-1) ≥ N_FLAGS.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sel_f  in  SEL_W  condition select: [SEL_W-1] = invert, [SEL_W-2:0] = flag index.
- escr_f  in  1  write enable for flags.
- mask_f  in  N_FLAGS  per-flag write enable, qualified by escr_f.
- r_flag  in  N_FLAGS-1  ALU flags.
- bit_maior_peso  in  1  ALU result MSB, written to flag N_FLAGS-1.
- push_f  in  1  save current flags to the stack.
- pop_f  in  1  restore flags from the stack.
- flags  out  N_FLAGS  current flag register.
- s_flag  out  1  selected condition.
- stack_full  out  1  stack holds STACK_DEPTH entries.
- stack_empty  out  1  stack holds 0 entries.
- stack_err  out  1  sticky overflow/underflow indicator.

## Operation
- Reset (rst=1 at an edge) sets:
  - flags = 0, stack pointer = 0, stack_err = 0.
  - stack_empty = 1, stack_full = 0.
  - Stack contents are don't-care.
- Flag write: on an edge with escr_f=1, each flag i with mask_f[i]=1 loads {bit_maior_peso, r_flag}[i]. Unmasked flags hold. escr_f=0 ignores mask_f.
- Condition select: let idx = sel_f[SEL_W-2:0] and raw = flags[idx] if idx < N_FLAGS, else 1 ("always"). Then s_flag = raw XOR sel_f[SEL_W-1]. Index ≥ N_FLAGS with invert set gives "never".
- Push (push_f=1, pop_f=0):
  - Not full: stack[sp] = flags as they were before this edge, sp+1.
  - Full: stack unchanged, stack_err set.
- Pop (pop_f=1, push_f=0):
  - Not empty: flags = stack[sp-1], sp-1. Pop takes priority over escr_f, whose write is dropped that cycle.
  - Empty: flags follow the normal escr_f rule, stack unchanged, stack_err set.
- push_f=1 and pop_f=1 together:
  - Stack and sp unchanged, stack_err unchanged.
  - escr_f is applied normally.
- Push together with escr_f: the stack stores the old flags, and the register takes the masked write in the same edge.
- stack_err stays set until rst; no other clear path.
- stack_full = (sp == STACK_DEPTH); stack_empty = (sp == 0). sp width is clog2(STACK_DEPTH+1); it never wraps.
- rst overrides every other input in the same edge. A push or pop issued alongside rst is lost.

## Timing
- flags, stack_full, stack_empty and stack_err are registered: updated 1 cycle after the enabling edge.
- s_flag is combinational from the flags register and sel_f:
  - zero-cycle response to sel_f;
  - a new flag value reaches s_flag 1 cycle after escr_f or pop.
- Back-to-back push/pop every cycle is supported; no handshake or stall.
- Flag written at edge n can be pushed at edge n+1 and shows the new value.

## Test plan
- Reset, then escr_f=1, mask_f=4'b1111, r_flag=3'b101, bit_maior_peso=1 → flags=4'b1101 next cycle. With sel_f=4'b0011, s_flag=1; with sel_f=4'b1011, s_flag=0.
- flags=4'b1101, escr_f=1, mask_f=4'b0010, r_flag=3'b010, bit_maior_peso=0 → flags=4'b1111 (only C changes).
- sel_f=4'b0100 → s_flag=1 regardless of flags; sel_f=4'b1111 → s_flag=0.
- Push A=4'b0001, B=4'b0010, C=4'b0100, D=4'b1000 (depth 4) → stack_full=1. A 5th push → stack_err=1 and the stack is unchanged. Four pops → flags read 1000, 0100, 0010, 0001 in turn, and stack_empty=1.
- Empty stack, pop_f=1 with escr_f=1, mask_f=4'b1111, inputs 4'b0110 → flags=4'b0110, stack_err=1. stack_err stays 1 until rst.
- flags=4'b0011, push_f=1 with escr_f=1 writing 4'b1100 → flags=4'b1100, sp=1. A following pop → flags=4'b0011.
